// File: rtl/mem_ctrl_pkg.sv
// Shared width defaults and FSM state encodings for the memory access unit.
// AR and the other datapath registers reuse the same width constants.
package mem_ctrl_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_DONE_ST = 2'd3;
endpackage

// File: rtl/mem_ctrl_array.sv
// Synchronous single-port RAM with a registered read port and no reset.
module mem_array
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_ctrl.sv
// Main-memory access FSM: latches a request in IDLE, counts wait states,
// then performs one array read or write and pulses DONE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              REST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              READ,
  input  logic              WRITE,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;

  // In IDLE the RAM is pointed at the live address so that with zero wait
  // states the registered read word is already valid on entering ACCESS.
  assign ram_addr = (state == S_IDLE) ? ADDR : lat_addr;
  assign ram_we   = (state == S_ACCESS) && lat_wr;

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (lat_data),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or posedge REST) begin
    if (REST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      DATA_OUT <= '0;
      ERR      <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (READ ^ WRITE) begin
            lat_addr <= ADDR;
            lat_data <= DATA_IN;
            lat_wr   <= WRITE;
            if (WAIT_STATES > 0) begin
              cnt   <= WS_CNT;
              state <= S_WAIT;
            end else begin
              state <= S_ACCESS;
            end
          end else if (READ && WRITE) begin
            ERR <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) state <= S_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          if (!lat_wr) DATA_OUT <= ram_dout;
          state <= S_DONE_ST;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_WAIT) || (state == S_ACCESS);
  assign DONE = (state == S_DONE_ST);
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a WAIT_STATES=2 instance driven from a vector
// table plus corner sequences, and a WAIT_STATES=0 instance for latency.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr0, addr1;
  logic [15:0] din0, din1;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] dout0, dout1;
  logic        busy0, done0, err0, busy1, done1, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(2)) dut0 (
    .clk(clk), .REST(rst), .ADDR(addr0), .DATA_IN(din0), .READ(rd0), .WRITE(wr0),
    .DATA_OUT(dout0), .BUSY(busy0), .DONE(done0), .ERR(err0)
  );

  mem_ctrl #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(0)) dut1 (
    .clk(clk), .REST(rst), .ADDR(addr1), .DATA_IN(din1), .READ(rd1), .WRITE(wr1),
    .DATA_OUT(dout1), .BUSY(busy1), .DONE(done1), .ERR(err1)
  );

  typedef struct {
    bit          is_wr;
    logic [11:0] a;
    logic [15:0] d;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One full access on the WAIT_STATES=2 instance; optionally scrambles the
  // request inputs right after the accepting edge.
  task automatic access0(input string nm, input bit is_wr, input logic [11:0] a,
                         input logic [15:0] d, input logic [15:0] exp_dout,
                         input bit scramble);
    int n, nb;
    addr0 = a; din0 = d; rd0 = !is_wr; wr0 = is_wr;
    tick();
    rd0 = 1'b0; wr0 = 1'b0;
    if (scramble) begin addr0 = 12'h000; din0 = 16'h0000; end
    n = 0;
    nb = busy0 ? 1 : 0;
    while (!done0 && n < 12) begin
      tick();
      n++;
      if (busy0) nb++;
    end
    chk({nm, " latency"}, n, 3);
    chk({nm, " busy_cycles"}, nb, 3);
    chk({nm, " dout"}, dout0, exp_dout);
    tick();
    chk({nm, " done_drop"}, {busy0, done0}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{1'b1, 12'h005, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 12'h005, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 12'h010, 16'hAAAA, 16'h1234};
    vecs[3] = '{1'b1, 12'h000, 16'h0F0F, 16'h1234};
    vecs[4] = '{1'b0, 12'h010, 16'hFFFF, 16'hAAAA};
    vecs[5] = '{1'b1, 12'h7FF, 16'h8001, 16'hAAAA};
    vecs[6] = '{1'b0, 12'h000, 16'h0000, 16'h0F0F};
    vecs[7] = '{1'b0, 12'h7FF, 16'h0000, 16'h8001};

    rst = 1'b1;
    addr0 = 12'h005; din0 = 16'h0; rd0 = 1'b1; wr0 = 1'b0;
    addr1 = 12'h000; din1 = 16'h0; rd1 = 1'b0; wr1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("reset%0d outs", i), {dout0, busy0, done0, err0}, {16'h0, 3'b000});
    end
    rd0 = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      access0($sformatf("vec%0d", i), vecs[i].is_wr, vecs[i].a, vecs[i].d,
              vecs[i].exp_dout, 1'b0);

    // READ and WRITE together: error pulse only.
    addr0 = 12'h005; din0 = 16'hDEAD; rd0 = 1'b1; wr0 = 1'b1;
    tick();
    chk("err pulse", {err0, busy0}, 2'b10);
    rd0 = 1'b0; wr0 = 1'b0;
    tick();
    chk("err drop", {err0, busy0, done0}, 3'b000);
    chk("err dout kept", dout0, 16'h8001);
    access0("err mem kept", 1'b0, 12'h005, 16'h0, 16'h1234, 1'b0);

    // Inputs changed during WAIT must not affect the write in flight.
    access0("latch wr", 1'b1, 12'hFFF, 16'hBEEF, 16'h1234, 1'b1);
    access0("latch rd fff", 1'b0, 12'hFFF, 16'h0, 16'hBEEF, 1'b0);
    access0("latch rd 000", 1'b0, 12'h000, 16'h0, 16'h0F0F, 1'b0);

    // Reset during WAIT aborts the write before it commits.
    addr0 = 12'h010; din0 = 16'h5555; wr0 = 1'b1;
    tick();
    wr0 = 1'b0;
    tick();
    chk("midrst busy before", busy0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst async", {dout0, busy0, done0}, {16'h0, 2'b00});
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("midrst idle", {busy0, done0}, 2'b00);
    access0("midrst rd", 1'b0, 12'h010, 16'h0, 16'hAAAA, 1'b0);

    // Zero-wait-state instance: preload, then a held read.
    addr1 = 12'h00A; din1 = 16'hC3C3; wr1 = 1'b1;
    tick();
    wr1 = 1'b0;
    chk("ws0 wr access", {busy1, done1}, 2'b10);
    tick();
    chk("ws0 wr done", {busy1, done1}, 2'b01);
    tick();
    rd1 = 1'b1;
    tick();
    chk("ws0 rd access", {busy1, done1}, 2'b10);
    tick();
    chk("ws0 rd done", {busy1, done1, dout1}, {2'b01, 16'hC3C3});
    tick();
    chk("ws0 idle gap", {busy1, done1}, 2'b00);
    tick();
    chk("ws0 reaccept", {busy1, done1}, 2'b10);
    rd1 = 1'b0;
    tick();
    chk("ws0 redone", {busy1, done1, dout1}, {2'b01, 16'hC3C3});
    tick();
    chk("ws0 final idle", {busy1, done1, err1}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Main-memory access unit sitting directly downstream of the address register. It takes the 12-bit address driven by AR's DATA_OUT and serves read/write requests from the control unit against an internal 4096-word array. Each access is a multi-cycle handshake with a parameterised number of wait states, so the controller can model slow memory. DATA_OUT feeds the common bus / DR.

Parameters:
ADDR_W, 12, address width; the array depth is 2**ADDR_W words.
DATA_W, 16, word width.
WAIT_STATES, 2, extra cycles inserted before the array access (range 0..15).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
REST  input  1  asynchronous, active-high reset.
ADDR  input  ADDR_W  access address, driven from AR DATA_OUT.
DATA_IN  input  DATA_W  write data.
READ  input  1  read request, level, sampled in IDLE only.
WRITE  input  1  write request, level, sampled in IDLE only.
DATA_OUT  output  DATA_W  last read word; held until the next read completes.
BUSY  output  1  high while an access is in progress (WAIT, ACCESS).
DONE  output  1  one-cycle pulse when an access completes.
ERR  output  1  one-cycle pulse when READ and WRITE are both high in IDLE.

Behaviour:
- Reset (REST high, async):
  - state=IDLE, DATA_OUT=0, BUSY=0, DONE=0, ERR=0, wait counter=0.
  - Array contents are not cleared.
  - Reset mid-operation aborts the access. A write that has not reached its ACCESS edge is never committed.
- States: IDLE, WAIT, ACCESS, DONE_ST.
- IDLE, at each rising edge:
  - READ xor WRITE high: accept the request. Latch ADDR, DATA_IN and the op into internal registers.
    - WAIT_STATES>0: cnt<=WAIT_STATES, go to WAIT.
    - WAIT_STATES=0: go to ACCESS.
  - READ and WRITE both high: no access; ERR=1 for exactly one cycle; stay in IDLE.
  - Neither high: stay in IDLE.
- WAIT: if cnt==1 go to ACCESS, else cnt<=cnt-1.
- ACCESS, at the edge:
  - Read: DATA_OUT<=mem[latched addr].
  - Write: mem[latched addr]<=latched data; DATA_OUT unchanged.
  - Go to DONE_ST.
- DONE_ST: DONE=1 for this one cycle, BUSY=0; go to IDLE at the next edge. Requests are not accepted in DONE_ST.
- BUSY=1 exactly in WAIT and ACCESS. All outputs are registered or decoded from state only (no combinational path from inputs).
- Latency: measured from the accepting edge E0, DONE is high after edge E0+WAIT_STATES+1.
  - Back-to-back requests held high are accepted every WAIT_STATES+3 cycles.
- Changes to ADDR, DATA_IN, READ or WRITE after E0 have no effect on the access in flight.
- Address space: the full 2**ADDR_W words with no out-of-range case. Address 0xFFF is valid and there is no wrap logic.
- A read of a never-written location returns X in simulation; benches write before reading.

Decomposition:
- Shared include file (von_neumann_defs): ADDR_W/DATA_W defaults and the state encodings (2-bit: IDLE=0, WAIT=1, ACCESS=2, DONE_ST=3). AR and the other registers reuse the width constants.
- One sub-module, mem_array: synchronous single-port RAM.
  - Inputs: clk, we, addr, din. Output: registered dout.
  - No reset.
- mem_ctrl holds the FSM, wait counter and request latches.

Test Plan:
- Reset: REST=1 for 2 cycles with READ=1 -> DATA_OUT=0, BUSY=0, DONE=0, ERR=0; no access starts while REST=1.
- Write then read, WAIT_STATES=2:
  - WRITE=1, ADDR=0x005, DATA_IN=0x1234 at edge E0 -> BUSY high E0..E3, DONE high after E3 only.
  - Then READ at 0x005 -> DATA_OUT=0x1234 with DONE.
- Latching:
  - Start a write of 0xBEEF to 0xFFF, then change ADDR to 0x000 and DATA_IN to 0x0000 during WAIT.
  - A later read of 0xFFF returns 0xBEEF; a read of 0x000 does not return 0xBEEF.
- Simultaneous READ=WRITE=1 in IDLE -> ERR pulses for 1 cycle, BUSY stays 0, memory and DATA_OUT unchanged.
- WAIT_STATES=0 build: read of a preloaded 0x00A -> DONE one edge after accept; READ held high -> new accept every 3 cycles.
- Reset mid-write:
  - Write 0x5555 to 0x010 (previously 0xAAAA), assert REST during WAIT.
  - FSM returns to IDLE; a subsequent read of 0x010 returns 0xAAAA.
